alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
- Execute-stage controller that sits directly upstream of alu_16bit and consumes its results.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives A/B/ALUCtrl to alu_16bit, samples S/Overflow/Zero, writes the result back and keeps sticky status flags.
- Multi-cycle: one instruction in flight.

Parameters:
- NREGS, 8, number of registers (power of two; index width log2(NREGS)=3).
- DW, 16, datapath width; must match alu_16bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept (IDLE and not ld_en).
- instr  in  16  [15:12] op (=ALUCtrl), [11:9] rd, [8:6] rs (->A), [5:3] rt (->B), [2:0] ignored.
- ld_en  in  1  external register load strobe.
- ld_addr  in  3  load target.
- ld_data  in  16  load value.
- dbg_addr  in  3  debug read index.
- dbg_data  out  16  combinational regfile[dbg_addr].
- alu_a  out  16  to alu_16bit.A (registered).
- alu_b  out  16  to alu_16bit.B (registered).
- alu_ctrl  out  4  to alu_16bit.ALUCtrl (registered).
- alu_s  in  16  from alu_16bit.S.
- alu_ovf  in  1  from alu_16bit.Overflow.
- alu_zero  in  1  from alu_16bit.Zero.
- done  out  1  one-cycle pulse at writeback.
- illegal  out  1  one-cycle pulse with done for unused op.
- zero_flag  out  1  sticky Zero of last legal op.
- ovf_flag  out  1  sticky Overflow of last legal op.

Behaviour:
- Reset (async, immediate): state=IDLE; all registers, alu_a, alu_b, alu_ctrl, zero_flag, ovf_flag = 0; done=illegal=0; instr_ready=1 once rst deasserts with ld_en=0.
- Register r0 is hardwired to 0; writes to r0 via load or writeback are discarded.
- Legal ops: 0 SUB, 1 ADD, 2 OR, 3 AND, 4 DEC, 5 INC, 6 INV, 8 LSL, 9 SLE, 10 LSR, 12 ASL, 14 ASR. Illegal: 7, 11, 13, 15.
- Unary ops (4, 5, 6) still drive alu_b=regfile[rt]; the ALU ignores it.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready = !ld_en. Handshake on instr_valid & instr_ready at a rising edge latches instr and goes to READ.
  - READ: alu_a<=reg[rs], alu_b<=reg[rt], alu_ctrl<=op.
  - EXEC: ALU settles; at the end of the cycle, capture alu_s, alu_ovf, alu_zero into internal result registers.
  - WB, legal op: reg[rd]<=result (unless rd=0); zero_flag<=captured zero; ovf_flag<=captured ovf; done=1.
  - WB, illegal op: no regfile write; flags unchanged; done=1, illegal=1.
- Latency: handshake at edge N; done high during cycle N+3 to N+4; the next handshake is possible at edge N+4 at the earliest. Throughput is 1 instruction per 4 cycles.
- Operand read uses regfile contents at READ, so a preceding instruction's writeback is always visible (no hazard logic needed).
- ld_en is honoured only in IDLE: reg[ld_addr]<=ld_data at the edge. ld_en outside IDLE is ignored.
- ld_en in IDLE forces instr_ready=0, so load has priority over a simultaneous instr_valid; the instruction stays pending.
- instr_valid while not ready: instr is not captured; the source must hold it.
- Reset mid-operation (any non-IDLE state): abort, no writeback, no done pulse, regfile cleared.
- dbg_data reflects the written value from the cycle after the write edge.

Test Plan:
- Load r1=4, r2=1; SUB rd=3 rs=1 rt=2 (instr 0x0650) -> done 3 cycles after accept, dbg r3=0x0003, zero_flag=0, ovf_flag=0.
- Load r1=0x7FFF, r2=0x0002; ADD rd=4 (0x1850) -> r4=0x8001, ovf_flag=1; then SUB r5=r1-r1 (0x0A48) -> r5=0, zero_flag=1, ovf_flag=0.
- ADD rd=0 with r1=4, r2=1 -> r0 stays 0x0000, zero_flag=0 (ALU result 5); load ld_addr=0, ld_data=0xFFFF -> r0 still 0.
- Op 7 (0x7650) -> done and illegal pulse together, all registers unchanged, flags retain prior values.
- ld_en=1 and instr_valid=1 in the same IDLE cycle -> instr_ready=0, load lands; instruction accepted the next cycle with ld_en=0 and uses the loaded value.
- Assert rst during EXEC of ADD r3 -> no done pulse, r3=0, state IDLE, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller for alu_16bit: fetches operands from an 8x16 register
// file, drives the ALU, captures its result and writes it back (4 cycles per instruction).
module alu_exec_ctrl #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [15:0]              instr,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [DW-1:0]            ld_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DW-1:0]            dbg_data,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [3:0]               alu_ctrl,
    input  logic [DW-1:0]            alu_s,
    input  logic                     alu_ovf,
    input  logic                     alu_zero,
    output logic                     done,
    output logic                     illegal,
    output logic                     zero_flag,
    output logic                     ovf_flag
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [12:0]   r_instr;
    logic [DW-1:0] r_regs [NREGS];
    logic [DW-1:0] r_res_s;
    logic          r_res_ovf;
    logic          r_res_zero;

    logic          w_accept;
    logic          w_legal;
    logic [3:0]    w_op;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic          w_unused_bits;

    // r_instr holds instr[15:3]; the low three bits carry no information.
    assign w_op          = r_instr[12:9];
    assign w_rd          = r_instr[8:6];
    assign w_rs          = r_instr[5:3];
    assign w_rt          = r_instr[2:0];
    assign w_unused_bits = ^instr[2:0];

    assign dbg_data = r_regs[dbg_addr];

    always_comb begin
        w_legal = 1'b1;
        case (w_op)
            4'd7, 4'd11, 4'd13, 4'd15: w_legal = 1'b0;
            default:                   w_legal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A pending load blocks acceptance so that it always wins over instr_valid.
    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = !ld_en;
                if (instr_valid && !ld_en) begin
                    w_accept     = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ:  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            r_res_s    <= '0;
            r_res_ovf  <= 1'b0;
            r_res_zero <= 1'b0;
            zero_flag  <= 1'b0;
            ovf_flag   <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;

            if (w_accept) begin
                r_instr <= instr[15:3];
            end

            case (r_state)
                S_IDLE: begin
                    // r0 is never written, so it stays at its reset value of zero.
                    if (ld_en && (ld_addr != '0)) begin
                        r_regs[ld_addr] <= ld_data;
                    end
                end
                S_READ: begin
                    alu_a    <= r_regs[w_rs];
                    alu_b    <= r_regs[w_rt];
                    alu_ctrl <= w_op;
                end
                S_EXEC: begin
                    r_res_s    <= alu_s;
                    r_res_ovf  <= alu_ovf;
                    r_res_zero <= alu_zero;
                end
                S_WB: begin
                    done <= 1'b1;
                    if (w_legal) begin
                        zero_flag <= r_res_zero;
                        ovf_flag  <= r_res_ovf;
                        if (w_rd != '0) begin
                            r_regs[w_rd] <= r_res_s;
                        end
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl; a behavioural alu_16bit model closes the loop.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_s;
    logic        alu_ovf;
    logic        alu_zero;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic        ovf_flag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_s       (alu_s),
        .alu_ovf     (alu_ovf),
        .alu_zero    (alu_zero),
        .done        (done),
        .illegal     (illegal),
        .zero_flag   (zero_flag),
        .ovf_flag    (ovf_flag)
    );

    // Behavioural stand-in for alu_16bit
    always_comb begin
        alu_s   = 16'h0000;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            4'd0: begin
                alu_s   = alu_a - alu_b;
                alu_ovf = (alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'd1: begin
                alu_s   = alu_a + alu_b;
                alu_ovf = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'd2:  alu_s = alu_a | alu_b;
            4'd3:  alu_s = alu_a & alu_b;
            4'd4:  alu_s = alu_a - 16'd1;
            4'd5:  alu_s = alu_a + 16'd1;
            4'd6:  alu_s = ~alu_a;
            4'd8:  alu_s = alu_a << 1;
            4'd9:  alu_s = {15'd0, ($signed(alu_a) <= $signed(alu_b))};
            4'd10: alu_s = alu_a >> 1;
            4'd12: alu_s = alu_a <<< 1;
            4'd14: alu_s = $signed(alu_a) >>> 1;
            default: alu_s = 16'h0000;
        endcase
        alu_zero = (alu_s == 16'h0000);
    end

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
        $display("load   r%0d <= 0x%04h", a, d);
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Offers an instruction, returns cycles from handshake edge to the done cycle.
    task automatic issue(input logic [15:0] ins, output int lat, output logic ill);
        int w;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        ill = illegal;
        $display("issue  0x%04h latency=%0d illegal=%0b z=%0b v=%0b", ins, lat, ill, zero_flag, ovf_flag);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        ld_en = 1'b0;
        ld_addr = 3'd0;
        ld_data = 16'h0000;
        dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        n_cmp++;
        if ({done, illegal, zero_flag, ovf_flag} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000", {done, illegal, zero_flag, ovf_flag});
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_ctrl} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_alu_regs: got %h want 0", {alu_a, alu_b, alu_ctrl});
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            n_cmp++;
            if (d !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_r%0d: got %h want 0000", i, d);
            end
        end
        $display("reset  checked");
    endtask

    task automatic test_sub();
        int lat;
        logic ill;
        logic [15:0] d;
        load(3'd1, 16'h0004);
        load(3'd2, 16'h0001);
        issue(16'h0650, lat, ill);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL sub_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (ill !== 1'b0) begin
            n_err++;
            $display("FAIL sub_illegal: got %b want 0", ill);
        end
        read_reg(3'd3, d);
        n_cmp++;
        if (d !== 16'h0003) begin
            n_err++;
            $display("FAIL sub_r3: got %h want 0003", d);
        end
        n_cmp++;
        if ({zero_flag, ovf_flag} !== 2'b00) begin
            n_err++;
            $display("FAIL sub_flags: got %b want 00", {zero_flag, ovf_flag});
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL sub_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_add_ovf_zero();
        int lat;
        logic ill;
        logic [15:0] d;
        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0002);
        issue(16'h1850, lat, ill);
        read_reg(3'd4, d);
        n_cmp++;
        if (d !== 16'h8001) begin
            n_err++;
            $display("FAIL add_r4: got %h want 8001", d);
        end
        n_cmp++;
        if ({zero_flag, ovf_flag} !== 2'b01) begin
            n_err++;
            $display("FAIL add_flags: got %b want 01", {zero_flag, ovf_flag});
        end
        issue(16'h0A48, lat, ill);
        read_reg(3'd5, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL sub_self_r5: got %h want 0000", d);
        end
        n_cmp++;
        if ({zero_flag, ovf_flag} !== 2'b10) begin
            n_err++;
            $display("FAIL sub_self_flags: got %b want 10", {zero_flag, ovf_flag});
        end
    endtask

    task automatic test_r0();
        int lat;
        logic ill;
        logic [15:0] d;
        load(3'd1, 16'h0004);
        load(3'd2, 16'h0001);
        issue(16'h1050, lat, ill);
        read_reg(3'd0, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL r0_wb: got %h want 0000", d);
        end
        n_cmp++;
        if (zero_flag !== 1'b0) begin
            n_err++;
            $display("FAIL r0_zero_flag: got %b want 0", zero_flag);
        end
        load(3'd0, 16'hFFFF);
        read_reg(3'd0, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL r0_load: got %h want 0000", d);
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic ill;
        logic [15:0] d;
        logic [15:0] exp_regs [8];
        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0002);
        issue(16'h1850, lat, ill);
        exp_regs = '{16'h0000, 16'h7FFF, 16'h0002, 16'h0003,
                     16'h8001, 16'h0000, 16'h0000, 16'h0000};
        issue(16'h7650, lat, ill);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL illegal_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (ill !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_pulse: got %b want 1", ill);
        end
        n_cmp++;
        if ({zero_flag, ovf_flag} !== 2'b01) begin
            n_err++;
            $display("FAIL illegal_flags: got %b want 01", {zero_flag, ovf_flag});
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            n_cmp++;
            if (d !== exp_regs[i]) begin
                n_err++;
                $display("FAIL illegal_r%0d: got %h want %h", i, d, exp_regs[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, illegal} !== 2'b00) begin
            n_err++;
            $display("FAIL illegal_one_cycle: got %b want 00", {done, illegal});
        end
    endtask

    task automatic test_load_priority();
        int lat;
        logic [15:0] d;
        @(negedge clk);
        ld_en       = 1'b1;
        ld_addr     = 3'd6;
        ld_data     = 16'h0010;
        instr       = 16'h1F90;
        instr_valid = 1'b1;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL prio_ready_low: got %b want 0", instr_ready);
        end
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL prio_ready_high: got %b want 1", instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL prio_latency: got %0d want 3", lat);
        end
        read_reg(3'd7, d);
        n_cmp++;
        if (d !== 16'h0012) begin
            n_err++;
            $display("FAIL prio_r7: got %h want 0012", d);
        end
        $display("prio   load r6=0x0010 then ADD r7 -> 0x%04h", d);
    endtask

    task automatic test_reset_mid_op();
        int seen;
        logic [15:0] d;
        @(negedge clk);
        instr       = 16'h1650;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", seen);
        end
        read_reg(3'd3, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL midrst_r3: got %h want 0000", d);
        end
        read_reg(3'd1, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL midrst_r1: got %h want 0000", d);
        end
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: got %b want 1", instr_ready);
        end
        $display("midrst reset during EXEC of ADD r3");
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add_ovf_zero();
        test_r0();
        test_illegal();
        test_load_priority();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
